// File: rtl/decode_stage.sv
// RV32I instruction-decode stage: register-file addressing, opcode/immediate/control
// decode, load-use interlock, and the ID/EX pipeline register with stall and flush.
module decode_stage #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               if_valid_i,
  input  logic [31:0]        if_instr_i,
  input  logic [XLEN-1:0]    if_pc_i,
  input  logic               flush_i,
  input  logic               ex_stall_i,
  output logic [4:0]         rs1_reg_o,
  output logic [4:0]         rs2_reg_o,
  input  logic [XLEN-1:0]    rs1_data_i,
  input  logic [XLEN-1:0]    rs2_data_i,
  output logic               stall_o,
  output logic               id_ex_valid_o,
  output logic [XLEN-1:0]    id_ex_pc_o,
  output logic [XLEN-1:0]    id_ex_rs1_data_o,
  output logic [XLEN-1:0]    id_ex_rs2_data_o,
  output logic [XLEN-1:0]    id_ex_imm_o,
  output logic [4:0]         id_ex_rs1_o,
  output logic [4:0]         id_ex_rs2_o,
  output logic [4:0]         id_ex_rd_o,
  output logic [ALUOP_W-1:0] id_ex_alu_op_o,
  output logic               id_ex_alu_src_imm_o,
  output logic               id_ex_reg_we_o,
  output logic               id_ex_mem_rd_o,
  output logic               id_ex_mem_wr_o,
  output logic               id_ex_branch_o,
  output logic               id_ex_jump_o,
  output logic               id_ex_illegal_o
);

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD   = ALUOP_W'(0),
    ALU_SUB   = ALUOP_W'(1),
    ALU_SLL   = ALUOP_W'(2),
    ALU_SLT   = ALUOP_W'(3),
    ALU_SLTU  = ALUOP_W'(4),
    ALU_XOR   = ALUOP_W'(5),
    ALU_SRL   = ALUOP_W'(6),
    ALU_SRA   = ALUOP_W'(7),
    ALU_OR    = ALUOP_W'(8),
    ALU_AND   = ALUOP_W'(9),
    ALU_PASSB = ALUOP_W'(10)
  } alu_op_e;

  typedef struct packed {
    logic               valid;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;
    logic [XLEN-1:0]    imm;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src_imm;
    logic               reg_we;
    logic               mem_rd;
    logic               mem_wr;
    logic               branch;
    logic               jump;
    logic               illegal;
  } id_ex_t;

  opcode_e         opc;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;

  assign opc       = opcode_e'(if_instr_i[6:0]);
  assign funct3    = if_instr_i[14:12];
  assign funct7    = if_instr_i[31:25];
  assign rd        = if_instr_i[11:7];
  assign rs1_reg_o = if_instr_i[19:15];
  assign rs2_reg_o = if_instr_i[24:20];

  assign imm_i = XLEN'($signed(if_instr_i[31:20]));
  assign imm_s = XLEN'($signed({if_instr_i[31:25], if_instr_i[11:7]}));
  assign imm_b = XLEN'($signed({if_instr_i[31], if_instr_i[7], if_instr_i[30:25],
                                if_instr_i[11:8], 1'b0}));
  assign imm_j = XLEN'($signed({if_instr_i[31], if_instr_i[19:12], if_instr_i[20],
                                if_instr_i[30:21], 1'b0}));
  assign imm_u = XLEN'($signed({if_instr_i[31:12], 12'b0}));

  // OP-IMM never subtracts; funct7[5] only selects SUB for register-register ops
  function automatic alu_op_e arith_op(input logic [2:0] f3, input logic alt, input logic is_reg);
    case (f3)
      3'b000:  arith_op = (alt && is_reg) ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  endfunction

  id_ex_t  dec;
  alu_op_e dec_op;
  logic    use_rs1, use_rs2;

  always_comb begin
    dec          = '0;
    dec_op       = ALU_ADD;
    use_rs1      = 1'b0;
    use_rs2      = 1'b0;
    dec.valid    = if_valid_i;
    dec.pc       = if_pc_i;
    dec.rs1_data = rs1_data_i;
    dec.rs2_data = rs2_data_i;
    dec.rs1      = rs1_reg_o;
    dec.rs2      = rs2_reg_o;
    dec.rd       = rd;
    case (opc)
      OPC_LUI: begin
        dec.imm = imm_u; dec_op = ALU_PASSB; dec.alu_src_imm = 1'b1; dec.reg_we = 1'b1;
      end
      OPC_AUIPC: begin
        dec.imm = imm_u; dec.alu_src_imm = 1'b1; dec.reg_we = 1'b1;
      end
      OPC_JAL: begin
        dec.imm = imm_j; dec.alu_src_imm = 1'b1; dec.reg_we = 1'b1; dec.jump = 1'b1;
      end
      OPC_JALR: begin
        dec.imm = imm_i; dec.alu_src_imm = 1'b1; dec.reg_we = 1'b1; dec.jump = 1'b1;
        use_rs1 = 1'b1;
      end
      OPC_BRANCH: begin
        dec.imm = imm_b; dec_op = ALU_SUB; dec.branch = 1'b1;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OPC_LOAD: begin
        dec.imm = imm_i; dec.alu_src_imm = 1'b1; dec.reg_we = 1'b1; dec.mem_rd = 1'b1;
        use_rs1 = 1'b1;
      end
      OPC_STORE: begin
        dec.imm = imm_s; dec.alu_src_imm = 1'b1; dec.mem_wr = 1'b1;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.imm = imm_i; dec.alu_src_imm = 1'b1; dec.reg_we = 1'b1;
        dec_op = arith_op(funct3, funct7[5], 1'b0);
        use_rs1 = 1'b1;
        if ((funct3 == 3'b001 && funct7 != 7'b0000000) ||
            (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000))
          dec.illegal = 1'b1;
      end
      OPC_OP: begin
        dec.reg_we = 1'b1;
        dec_op = arith_op(funct3, funct7[5], 1'b1);
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.alu_op = dec_op;
    if (rd == 5'd0 || dec.illegal)
      dec.reg_we = 1'b0;
  end

  id_ex_t q;
  logic   load_use;

  assign load_use = q.valid && q.mem_rd && (q.rd != 5'd0) && if_valid_i &&
                    ((use_rs1 && q.rd == rs1_reg_o) || (use_rs2 && q.rd == rs2_reg_o));

  // A flush kills whatever is in ID, so it never needs to freeze the front end
  assign stall_o = !flush_i && (ex_stall_i || load_use);

  always_ff @(posedge clk) begin
    if (!rst_n)
      q <= '0;
    else if (flush_i)
      q <= '0;
    else if (!ex_stall_i)
      q <= (load_use || !if_valid_i) ? '0 : dec;
  end

  assign id_ex_valid_o       = q.valid;
  assign id_ex_pc_o          = q.pc;
  assign id_ex_rs1_data_o    = q.rs1_data;
  assign id_ex_rs2_data_o    = q.rs2_data;
  assign id_ex_imm_o         = q.imm;
  assign id_ex_rs1_o         = q.rs1;
  assign id_ex_rs2_o         = q.rs2;
  assign id_ex_rd_o          = q.rd;
  assign id_ex_alu_op_o      = q.alu_op;
  assign id_ex_alu_src_imm_o = q.alu_src_imm;
  assign id_ex_reg_we_o      = q.reg_we;
  assign id_ex_mem_rd_o      = q.mem_rd;
  assign id_ex_mem_wr_o      = q.mem_wr;
  assign id_ex_branch_o      = q.branch;
  assign id_ex_jump_o        = q.jump;
  assign id_ex_illegal_o     = q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expected ID/EX contents are queued when an
// instruction is presented and compared after the capturing edge.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid_i;
  logic [31:0] if_instr_i;
  logic [31:0] if_pc_i;
  logic        flush_i;
  logic        ex_stall_i;
  logic [4:0]  rs1_reg_o, rs2_reg_o;
  logic [31:0] rs1_data_i, rs2_data_i;
  logic        stall_o;
  logic        id_ex_valid_o;
  logic [31:0] id_ex_pc_o, id_ex_rs1_data_o, id_ex_rs2_data_o, id_ex_imm_o;
  logic [4:0]  id_ex_rs1_o, id_ex_rs2_o, id_ex_rd_o;
  logic [3:0]  id_ex_alu_op_o;
  logic        id_ex_alu_src_imm_o, id_ex_reg_we_o, id_ex_mem_rd_o, id_ex_mem_wr_o;
  logic        id_ex_branch_o, id_ex_jump_o, id_ex_illegal_o;

  decode_stage #(.XLEN(32), .ALUOP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid_i(if_valid_i), .if_instr_i(if_instr_i),
    .if_pc_i(if_pc_i), .flush_i(flush_i), .ex_stall_i(ex_stall_i),
    .rs1_reg_o(rs1_reg_o), .rs2_reg_o(rs2_reg_o),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .stall_o(stall_o),
    .id_ex_valid_o(id_ex_valid_o), .id_ex_pc_o(id_ex_pc_o),
    .id_ex_rs1_data_o(id_ex_rs1_data_o), .id_ex_rs2_data_o(id_ex_rs2_data_o),
    .id_ex_imm_o(id_ex_imm_o), .id_ex_rs1_o(id_ex_rs1_o), .id_ex_rs2_o(id_ex_rs2_o),
    .id_ex_rd_o(id_ex_rd_o), .id_ex_alu_op_o(id_ex_alu_op_o),
    .id_ex_alu_src_imm_o(id_ex_alu_src_imm_o), .id_ex_reg_we_o(id_ex_reg_we_o),
    .id_ex_mem_rd_o(id_ex_mem_rd_o), .id_ex_mem_wr_o(id_ex_mem_wr_o),
    .id_ex_branch_o(id_ex_branch_o), .id_ex_jump_o(id_ex_jump_o),
    .id_ex_illegal_o(id_ex_illegal_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, r1d, r2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  op;
    logic        si, we, mrd, mwr, br, jmp, ill;
  } idex_t;

  localparam logic [6:0] C_SI  = 7'b1000000;
  localparam logic [6:0] C_WE  = 7'b0100000;
  localparam logic [6:0] C_MRD = 7'b0010000;
  localparam logic [6:0] C_MWR = 7'b0001000;
  localparam logic [6:0] C_BR  = 7'b0000100;
  localparam logic [6:0] C_JMP = 7'b0000010;
  localparam logic [6:0] C_ILL = 7'b0000001;

  int    n_checks = 0;
  int    n_fail   = 0;
  idex_t exp_q[$];
  idex_t mask_q[$];
  string tag_q[$];

  function automatic idex_t mk(input logic [31:0] pc, r1d, r2d, imm,
                               input logic [4:0] rs1, rs2, rd,
                               input logic [3:0] op, input logic [6:0] ctl);
    idex_t r;
    r.valid = 1'b1; r.pc = pc; r.r1d = r1d; r.r2d = r2d; r.imm = imm;
    r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.op = op;
    {r.si, r.we, r.mrd, r.mwr, r.br, r.jmp, r.ill} = ctl;
    return r;
  endfunction

  function automatic idex_t observed();
    idex_t r;
    r.valid = id_ex_valid_o; r.pc = id_ex_pc_o; r.r1d = id_ex_rs1_data_o;
    r.r2d = id_ex_rs2_data_o; r.imm = id_ex_imm_o; r.rs1 = id_ex_rs1_o;
    r.rs2 = id_ex_rs2_o; r.rd = id_ex_rd_o; r.op = id_ex_alu_op_o;
    {r.si, r.we, r.mrd, r.mwr, r.br, r.jmp, r.ill} =
      {id_ex_alu_src_imm_o, id_ex_reg_we_o, id_ex_mem_rd_o, id_ex_mem_wr_o,
       id_ex_branch_o, id_ex_jump_o, id_ex_illegal_o};
    return r;
  endfunction

  idex_t M_ALL, M_CTRL, M_BADSH, ZERO;

  task automatic step(input string tag, input logic rst, input logic v,
                      input logic [31:0] instr, pc, d1, d2,
                      input logic fl, es, chk_st, exp_st,
                      input idex_t e, input idex_t m);
    idex_t ee, mm, oo;
    string t;
    rst_n = rst; if_valid_i = v; if_instr_i = instr; if_pc_i = pc;
    rs1_data_i = d1; rs2_data_i = d2; flush_i = fl; ex_stall_i = es;
    #1;
    if (chk_st) begin
      n_checks++;
      assert (stall_o === exp_st) else begin
        n_fail++;
        $error("FAIL %s stall_o observed=%b expected=%b", tag, stall_o, exp_st);
      end
    end
    exp_q.push_back(e); mask_q.push_back(m); tag_q.push_back(tag);
    @(posedge clk); #1;
    ee = exp_q.pop_front(); mm = mask_q.pop_front(); t = tag_q.pop_front();
    oo = observed();
    n_checks++;
    assert ((oo & mm) === (ee & mm)) else begin
      n_fail++;
      $error("FAIL %s id_ex observed=%h expected=%h", t, oo & mm, ee & mm);
    end
  endtask

  localparam logic [31:0] I_ADDI  = 32'hFFD08293; // addi x5,x1,-3
  localparam logic [31:0] I_LW6   = 32'h00012303; // lw   x6,0(x2)
  localparam logic [31:0] I_ADD76 = 32'h003303B3; // add  x7,x6,x3
  localparam logic [31:0] I_LW0   = 32'h00012003; // lw   x0,0(x2)
  localparam logic [31:0] I_ADD70 = 32'h003003B3; // add  x7,x0,x3
  localparam logic [31:0] I_SUB   = 32'h40538433; // sub  x8,x7,x5
  localparam logic [31:0] I_BEQ   = 32'h00230863; // beq  x6,x2,16
  localparam logic [31:0] I_BNE   = 32'hFE209EE3; // bne  x1,x2,-4
  localparam logic [31:0] I_LUI   = 32'h12345537; // lui  x10,0x12345
  localparam logic [31:0] I_SW    = 32'h00512423; // sw   x5,8(x2)
  localparam logic [31:0] I_JAL   = 32'h008000EF; // jal  x1,8
  localparam logic [31:0] I_SRAI  = 32'h4030D293; // srai x5,x1,3
  localparam logic [31:0] I_BADSH = 32'h6030D293; // srai with funct7=0110000
  localparam logic [31:0] I_ILL   = 32'h0000007F;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idex_t e_add70;
    M_ALL = '1;
    M_CTRL = '0;
    M_CTRL.valid = 1'b1;
    {M_CTRL.si, M_CTRL.we, M_CTRL.mrd, M_CTRL.mwr, M_CTRL.br, M_CTRL.jmp, M_CTRL.ill} = '1;
    M_BADSH = '0;
    M_BADSH.valid = 1'b1; M_BADSH.ill = 1'b1; M_BADSH.we = 1'b1;
    M_BADSH.mrd = 1'b1; M_BADSH.mwr = 1'b1;
    ZERO = '0;

    step("reset0", 0, 1, I_ADDI, 32'h100, 32'd10, 32'h22, 0, 0, 0, 0, ZERO, M_ALL);
    step("reset1", 0, 1, I_ADDI, 32'h100, 32'd10, 32'h22, 0, 0, 1, 0, ZERO, M_ALL);
    step("addi", 1, 1, I_ADDI, 32'h100, 32'd10, 32'h22, 0, 0, 1, 0,
         mk(32'h100, 32'd10, 32'h22, 32'hFFFFFFFD, 5'd1, 5'd29, 5'd5, 4'd0, C_SI | C_WE), M_ALL);
    step("lw_x6", 1, 1, I_LW6, 32'h104, 32'h1000, 32'h0, 0, 0, 1, 0,
         mk(32'h104, 32'h1000, 32'h0, 32'h0, 5'd2, 5'd0, 5'd6, 4'd0, C_SI | C_WE | C_MRD), M_ALL);
    step("load_use_bubble", 1, 1, I_ADD76, 32'h108, 32'hAA, 32'h33, 0, 0, 1, 1, ZERO, M_CTRL);
    step("add_after_stall", 1, 1, I_ADD76, 32'h108, 32'h55, 32'h33, 0, 0, 1, 0,
         mk(32'h108, 32'h55, 32'h33, 32'h0, 5'd6, 5'd3, 5'd7, 4'd0, C_WE), M_ALL);
    step("lw_x0", 1, 1, I_LW0, 32'h10C, 32'h1000, 32'h0, 0, 0, 1, 0,
         mk(32'h10C, 32'h1000, 32'h0, 32'h0, 5'd2, 5'd0, 5'd0, 4'd0, C_SI | C_MRD), M_ALL);
    e_add70 = mk(32'h110, 32'h0, 32'h33, 32'h0, 5'd0, 5'd3, 5'd7, 4'd0, C_WE);
    step("lw_x0_no_stall", 1, 1, I_ADD70, 32'h110, 32'h0, 32'h33, 0, 0, 1, 0, e_add70, M_ALL);
    for (int i = 0; i < 3; i++)
      step("ex_stall_hold", 1, 1, I_SUB, 32'h114, 32'h77, 32'h5, 0, 1, 1, 1, e_add70, M_ALL);
    step("sub_after_hold", 1, 1, I_SUB, 32'h114, 32'h77, 32'h5, 0, 0, 1, 0,
         mk(32'h114, 32'h77, 32'h5, 32'h0, 5'd7, 5'd5, 5'd8, 4'd1, C_WE), M_ALL);
    step("lw_x6_b", 1, 1, I_LW6, 32'h118, 32'h1000, 32'h0, 0, 0, 1, 0,
         mk(32'h118, 32'h1000, 32'h0, 32'h0, 5'd2, 5'd0, 5'd6, 4'd0, C_SI | C_WE | C_MRD), M_ALL);
    step("flush_over_hazard", 1, 1, I_BEQ, 32'h11C, 32'h1, 32'h2, 1, 0, 1, 0, ZERO, M_CTRL);
    step("bne", 1, 1, I_BNE, 32'h200, 32'h1, 32'h2, 0, 0, 1, 0,
         mk(32'h200, 32'h1, 32'h2, 32'hFFFFFFFC, 5'd1, 5'd2, 5'd29, 4'd1, C_BR), M_ALL);
    step("flush_and_ex_stall", 1, 1, I_LUI, 32'h204, 32'h0, 32'h0, 1, 1, 1, 0, ZERO, M_CTRL);
    step("lui", 1, 1, I_LUI, 32'h204, 32'h3, 32'h4, 0, 0, 1, 0,
         mk(32'h204, 32'h3, 32'h4, 32'h12345000, 5'd8, 5'd3, 5'd10, 4'd10, C_SI | C_WE), M_ALL);
    step("sw", 1, 1, I_SW, 32'h208, 32'h2000, 32'h1234, 0, 0, 1, 0,
         mk(32'h208, 32'h2000, 32'h1234, 32'h8, 5'd2, 5'd5, 5'd8, 4'd0, C_SI | C_MWR), M_ALL);
    step("jal", 1, 1, I_JAL, 32'h20C, 32'h0, 32'h0, 0, 0, 1, 0,
         mk(32'h20C, 32'h0, 32'h0, 32'h8, 5'd0, 5'd8, 5'd1, 4'd0, C_SI | C_WE | C_JMP), M_ALL);
    step("srai", 1, 1, I_SRAI, 32'h210, 32'h80000000, 32'h0, 0, 0, 1, 0,
         mk(32'h210, 32'h80000000, 32'h0, 32'h403, 5'd1, 5'd3, 5'd5, 4'd7, C_SI | C_WE), M_ALL);
    step("illegal_opcode", 1, 1, I_ILL, 32'h214, 32'h11, 32'h22, 0, 0, 1, 0,
         mk(32'h214, 32'h11, 32'h22, 32'h0, 5'd0, 5'd0, 5'd0, 4'd0, C_ILL), M_ALL);
    step("bad_shift_funct7", 1, 1, I_BADSH, 32'h218, 32'h0, 32'h0, 0, 0, 1, 0,
         mk(32'h218, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 4'd0, C_ILL), M_BADSH);
    step("if_invalid_bubble", 1, 0, I_LW6, 32'h21C, 32'h0, 32'h0, 0, 0, 1, 0, ZERO, M_CTRL);
    step("lw_x6_c", 1, 1, I_LW6, 32'h300, 32'h1000, 32'h0, 0, 0, 1, 0,
         mk(32'h300, 32'h1000, 32'h0, 32'h0, 5'd2, 5'd0, 5'd6, 4'd0, C_SI | C_WE | C_MRD), M_ALL);
    step("reset_mid_stall", 0, 1, I_ADD76, 32'h304, 32'h9, 32'h33, 0, 0, 0, 0, ZERO, M_ALL);
    step("add_after_reset", 1, 1, I_ADD76, 32'h304, 32'h9, 32'h33, 0, 0, 1, 0,
         mk(32'h304, 32'h9, 32'h33, 32'h0, 5'd6, 5'd3, 5'd7, 4'd0, C_WE), M_ALL);

    n_checks++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode stage of the RV32I five-stage pipeline, between the IF/ID register and EX.
- Drives the register-file read addresses combinationally and captures the returned operands.
- Decodes opcode, immediate and control, and registers everything into the ID/EX pipeline register.
- Owns the load-use interlock plus the stall and flush handling for the ID/EX boundary.

Parameters:
- XLEN, 32, datapath width.
- ALUOP_W, 4, width of the ALU operation code.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- if_valid_i  in  1  IF/ID holds a valid instruction.
- if_instr_i  in  32  instruction word.
- if_pc_i  in  XLEN  PC of the instruction.
- flush_i  in  1  redirect from EX; kill the instruction in ID.
- ex_stall_i  in  1  EX cannot accept; hold ID/EX.
- rs1_reg_o  out  5  register-file read address 1 = if_instr_i[19:15].
- rs2_reg_o  out  5  register-file read address 2 = if_instr_i[24:20].
- rs1_data_i  in  XLEN  register-file read data 1 (write-back bypass already applied).
- rs2_data_i  in  XLEN  register-file read data 2.
- stall_o  out  1  freeze PC and IF/ID this cycle.
- id_ex_valid_o  out  1  ID/EX holds a live instruction.
- id_ex_pc_o  out  XLEN  registered PC.
- id_ex_rs1_data_o, id_ex_rs2_data_o  out  XLEN  registered operands.
- id_ex_imm_o  out  XLEN  sign-extended immediate.
- id_ex_rs1_o, id_ex_rs2_o, id_ex_rd_o  out  5  registered indices, used by EX forwarding.
- id_ex_alu_op_o  out  ALUOP_W  ALU operation.
- id_ex_alu_src_imm_o, id_ex_reg_we_o, id_ex_mem_rd_o, id_ex_mem_wr_o, id_ex_branch_o, id_ex_jump_o, id_ex_illegal_o  out  1  control bits.

Behaviour:
- Reset (rst_n=0 at posedge): all id_ex_* outputs become 0. stall_o is combinational and reads 0 while ID/EX is reset.
- Opcodes decoded: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011.
  - Any other opcode: illegal=1 and reg_we/mem_rd/mem_wr/branch/jump=0.
  - OP-IMM shifts with a bad funct7 are also illegal.
- Immediates (I/S/B/J/U forms) are sign-extended to XLEN. B and J immediates have bit 0 = 0. The U form is instr[31:12]<<12.
- ALU op codes: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASSB=10.
  - LUI uses PASSB.
  - AUIPC, LOAD, STORE, JAL and JALR use ADD.
  - BRANCH uses SUB.
- Register-use flags:
  - rs1 is used by every opcode except LUI, AUIPC and JAL.
  - rs2 is used by BRANCH, STORE and OP.
  - reg_we=0 when rd=0.
- Load-use hazard, combinational:
  - Condition: id_ex_valid_o & id_ex_mem_rd_o & id_ex_rd_o!=0 & if_valid_i, and id_ex_rd_o matches a used source register.
  - Response: stall_o=1, and a bubble (id_ex_valid_o=0, all control bits 0) is written into ID/EX at the next edge.
  - The instruction is re-decoded the following cycle, so the stall lasts exactly 1 cycle.
- Priority at each posedge:
  1. flush_i: ID/EX becomes a bubble; stall_o=0.
  2. ex_stall_i: ID/EX holds its value; stall_o=1.
  3. Load-use: bubble inserted, stall_o=1.
  4. Otherwise ID/EX captures the decode of IF/ID; id_ex_valid_o = if_valid_i.
- flush_i with ex_stall_i: the flush wins and the bubble replaces the held content.
- if_valid_i=0: no hazard is raised and a bubble is written.
- rd=0 with mem_rd: never raises a hazard.
- Operands are captured in the same cycle they are read, so latency is 1 cycle from IF/ID to ID/EX.
- Reset asserted mid-stall clears ID/EX; stall_o drops because id_ex_valid_o=0.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with if_valid_i=1 -> all id_ex_* = 0 and stall_o=0; the first instruction is captured 1 cycle after release.
- ADDI x5,x1,-3 (0xFFD08293) with rs1_data_i=10 -> next cycle: imm=0xFFFFFFFD, alu_op=ADD, alu_src_imm=1, rd=5, reg_we=1, rs1_data=10.
- Load-use pair:
  - Stimulus: LW x6,0(x2), then ADD x7,x6,x3.
  - Required: one stall_o=1 cycle with a bubble in ID/EX, then the ADD is issued with rs1=6.
  - Repeat with LW x0 -> no stall.
- Flush: flush_i=1 while BEQ is in ID -> id_ex_valid_o=0 next cycle, and stall_o=0 even if a load-use condition is present.
- EX stall: ex_stall_i=1 for 3 cycles -> id_ex_* are stable, stall_o=1 throughout, and the instruction after release is not lost or duplicated.
- Illegal opcode 0x0000007F -> id_ex_illegal_o=1, id_ex_valid_o=1, and reg_we/mem_rd/mem_wr=0.
